// File: rtl/ws2812_pkg.sv
// Shared types, default 50 MHz timing and wire-order helper
// for the WS2812 stream driver.
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } state_e;

   localparam int T0H_DEF   = 20;
   localparam int T1H_DEF   = 40;
   localparam int BIT_DEF   = 63;
   localparam int RESET_DEF = 25000;

   // Bit n of an RGB word in wire order: G7..G0, R7..R0, B7..B0.
   function automatic logic wire_bit(
      input logic [23:0] rgb,
      input logic [4:0]  n
   );
      logic [23:0] grb;
      grb = {rgb[15:8], rgb[23:16], rgb[7:0]};
      return grb[5'd23 - n];
   endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// NRZ bit-cell timer: owns the per-bit cycle counter and
// registers the line level for the coming cycle.
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int T0H_CYC = T0H_DEF,
   parameter int T1H_CYC = T1H_DEF,
   parameter int BIT_CYC = BIT_DEF,
   parameter int CW      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic adv_i,
   input  logic act_i,
   input  logic bit_i,
   output logic level_o,
   output logic bit_last_o
);

   logic [CW-1:0] cyc_q, cyc_d;
   logic [CW-1:0] thr;
   logic          lvl_d;

   assign bit_last_o = (cyc_q == CW'(BIT_CYC - 1));

   // level is computed for the cycle the counter is about to enter
   always_comb begin
      cyc_d = cyc_q;
      if (load_i) begin
         cyc_d = '0;
      end else if (adv_i) begin
         cyc_d = bit_last_o ? '0 : cyc_q + 1'b1;
      end
      thr   = bit_i ? CW'(T1H_CYC) : CW'(T0H_CYC);
      lvl_d = act_i && (cyc_d < thr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q   <= '0;
         level_o <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         level_o <= lvl_d;
      end
   end

endmodule

// File: rtl/ws2812_stream_driver.sv
// Serialises a frame of RGB words onto a WS2812 data line,
// followed by the latch gap and a done pulse.
module ws2812_stream_driver
   import ws2812_pkg::*;
#(
   parameter int LEDS      = 50,
   parameter int T0H_CYC   = T0H_DEF,
   parameter int T1H_CYC   = T1H_DEF,
   parameter int BIT_CYC   = BIT_DEF,
   parameter int RESET_CYC = RESET_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [24*LEDS-1:0]   led_rgb,
   input  logic                 start,
   output logic                 data_out,
   output logic                 done,
   output logic                 busy
);

   localparam int NBITS = 24 * LEDS;
   localparam int BW    = $clog2(NBITS);
   localparam int CMAX  = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int CW    = $clog2(CMAX);
   localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(RESET_CYC - 1);

   if (!(LEDS >= 1 && T0H_CYC >= 1 && T0H_CYC < T1H_CYC &&
         T1H_CYC < BIT_CYC && RESET_CYC >= 1)) begin : g_bad_params
      $error("ws2812_stream_driver: illegal timing parameters");
   end

   state_e             state_q, state_d;
   logic [NBITS-1:0]   shadow_q, shadow_d;
   logic [BW-1:0]      bit_idx_q, bit_idx_d;
   logic [4:0]         bitn_q, bitn_d;
   logic [CW-1:0]      lat_q, lat_d;
   logic               done_q, done_d;
   logic [23:0]        word_d;
   logic               nxt_bit;
   logic               load;
   logic               send;
   logic               bit_last;
   logic               frame_last;
   logic               lat_last;

   assign send       = (state_q == SEND);
   assign lat_last   = (lat_q == LAT_LAST);
   assign frame_last = send && bit_last && (bit_idx_q == LAST_BIT);
   assign done       = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LATCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)      state_d = SEND;
         SEND:    if (frame_last) state_d = LATCH;
         LATCH:   if (lat_last)   state_d = IDLE;
         default:                 state_d = LATCH;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      load   = (state_q == IDLE) && start;
      done_d = (state_q == LATCH) && lat_last;
   end

   // shadow shifts one LED per 24 bits so the active word is always on top
   always_comb begin
      shadow_d  = shadow_q;
      bit_idx_d = bit_idx_q;
      bitn_d    = bitn_q;
      lat_d     = '0;
      if (load) begin
         shadow_d  = led_rgb;
         bit_idx_d = '0;
         bitn_d    = '0;
      end else if (send && bit_last) begin
         bit_idx_d = frame_last ? '0 : bit_idx_q + 1'b1;
         if (bitn_q == 5'd23) begin
            bitn_d   = '0;
            shadow_d = shadow_q << 24;
         end else begin
            bitn_d = bitn_q + 1'b1;
         end
      end
      if (state_q == LATCH && !lat_last) lat_d = lat_q + 1'b1;
      word_d  = shadow_d[NBITS-1 -: 24];
      nxt_bit = wire_bit(word_d, bitn_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q  <= '0;
         bit_idx_q <= '0;
         bitn_q    <= '0;
         lat_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         bit_idx_q <= bit_idx_d;
         bitn_q    <= bitn_d;
         lat_q     <= lat_d;
         done_q    <= done_d;
      end
   end

   ws2812_bit_encoder #(
      .T0H_CYC (T0H_CYC),
      .T1H_CYC (T1H_CYC),
      .BIT_CYC (BIT_CYC),
      .CW      (CW)
   ) u_enc (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .adv_i      (send),
      .act_i      (state_d == SEND),
      .bit_i      (nxt_bit),
      .level_o    (data_out),
      .bit_last_o (bit_last)
   );

endmodule
